// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: nibble-serial add/subtract controller around one 4-bit Brent-Kung adder.
module bk_add4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);
    logic [3:0] w_g, w_p;
    logic       w_g10, w_p10, w_g32, w_p32, w_c1, w_c2, w_c3;
    assign w_g   = a_i & b_i;
    assign w_p   = a_i ^ b_i;
    assign w_g10 = w_g[1] | (w_p[1] & w_g[0]);
    assign w_p10 = &w_p[1:0];
    assign w_g32 = w_g[3] | (w_p[3] & w_g[2]);
    assign w_p32 = &w_p[3:2];
    assign w_c1  = w_g[0] | (w_p[0] & c_i);
    assign w_c2  = w_g10 | (w_p10 & c_i);
    assign w_c3  = w_g[2] | (w_p[2] & w_c2);
    assign c_o   = w_g32 | (w_p32 & w_c2);
    assign s_o   = w_p ^ {w_c3, w_c2, w_c1, c_i};
endmodule

module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    input  logic             carry_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             ovf_o,
    output logic             zero_o
);
    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a, r_b, r_sum;
    logic [IW-1:0]    r_idx;
    logic             r_c, r_ready, r_valid, r_cout, r_ovf, r_zero;

    logic [IW+1:0]    w_sh;
    logic [3:0]       w_an, w_bn, w_s;
    logic             w_co, w_last;
    logic [WIDTH-1:0] w_sum_nx;

    assign w_sh     = {r_idx, 2'b00};
    assign w_an     = 4'(r_a >> w_sh);
    assign w_bn     = 4'(r_b >> w_sh);
    assign w_last   = r_idx == IW'(N - 1);
    // Splice this cycle's nibble into the partial result so the full sum exists on the last cycle.
    assign w_sum_nx = (r_sum & ~(WIDTH'(4'hF) << w_sh)) | (WIDTH'(w_s) << w_sh);

    bk_add4 u_add (
        .a_i (w_an),
        .b_i (w_bn),
        .c_i (r_c),
        .s_o (w_s),
        .c_o (w_co)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_c     <= 1'b0;
            r_ready <= 1'b0;
            r_valid <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid_i && r_ready) begin
                        r_a     <= a_i;
                        r_b     <= sub_i ? ~b_i : b_i;
                        r_c     <= sub_i | carry_i;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_ready <= 1'b0;
                        r_state <= BUSY;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                BUSY: begin
                    r_sum <= w_sum_nx;
                    r_c   <= w_co;
                    r_idx <= r_idx + IW'(1);
                    if (w_last) begin
                        r_state <= DONE;
                        r_valid <= 1'b1;
                        r_cout  <= w_co;
                        r_ovf   <= r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_sum_nx[WIDTH-1] ^ w_co;
                        r_zero  <= w_sum_nx == '0;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = r_ready;
    assign out_valid_o = r_valid;
    assign sum_o       = r_sum;
    assign carry_o     = r_cout;
    assign ovf_o       = r_ovf;
    assign zero_o      = r_zero;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl: scoreboard bench for nibble_serial_add_ctrl against an arithmetic model.
module tb_nibble_serial_add_ctrl;
    localparam int W = 16;
    localparam int N = W / 4;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        logic         z;
    } exp_t;

    logic         clk = 1'b0, rst_i = 1'b1, in_valid_i = 1'b0, sub_i = 1'b0, carry_i = 1'b0, out_ready_i = 1'b0;
    logic [W-1:0] a_i = '0, b_i = '0;
    logic         in_ready_o, out_valid_o, carry_o, ovf_o, zero_o;
    logic [W-1:0] sum_o;

    int   checks = 0, errors = 0, cyc = 0, rmode = 0;
    exp_t exp_q[$];
    int   acc_q[$];
    logic pv = 1'b0, pr = 1'b0;
    exp_t held;

    nibble_serial_add_ctrl #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .sub_i       (sub_i),
        .carry_i     (carry_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .sum_o       (sum_o),
        .carry_o     (carry_o),
        .ovf_o       (ovf_o),
        .zero_o      (zero_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Consumer back-pressure: random, forced low, or forced high.
    initial forever begin
        @(posedge clk);
        #2 out_ready_i = (rmode == 0) ? ($urandom_range(0, 3) != 0) : (rmode == 2);
    end

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic c);
        logic [W-1:0] nb;
        logic [W:0]   f;
        int           sr;
        exp_t         e;
        nb = ~b;
        f  = s ? (17'(a) + 17'(nb) + 17'd1) : (17'(a) + 17'(b) + 17'(c));
        sr = s ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)) + int'(c));
        e.s = f[W-1:0];
        e.c = f[W];
        e.v = (sr > 32767) || (sr < -32768);
        e.z = f[W-1:0] == '0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at cycle %0d", name, got, req, cyc);
        end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic c, input bit hold);
        int t = 0;
        @(negedge clk);
        while (!in_ready_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("accept_wait", 32'(in_ready_o), 32'd1);
        a_i = a;
        b_i = b;
        sub_i = s;
        carry_i = c;
        in_valid_i = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(model(a, b, s, c));
        acc_q.push_back(cyc);
        if (!hold) begin
            in_valid_i = 1'b0;
            a_i = W'($urandom);
            b_i = W'($urandom);
            sub_i = 1'($urandom);
            carry_i = 1'($urandom);
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_i) begin
            pv <= 1'b0;
            pr <= 1'b0;
        end else begin
            if (out_valid_o && !pv) begin
                if (acc_q.size() == 0) chk("spurious_valid", 32'd1, 32'd0);
                else chk("latency", 32'(cyc - acc_q.pop_front()), 32'(N));
            end
            if (pv && !pr) begin
                chk("valid_held", 32'(out_valid_o), 32'd1);
                chk("stable", 32'({sum_o, carry_o, ovf_o, zero_o}), 32'(held));
            end
            if (out_valid_o) chk("ready_in_done", 32'(in_ready_o), 32'd0);
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
                else chk("result", 32'({sum_o, carry_o, ovf_o, zero_o}), 32'(exp_q.pop_front()));
            end
            held <= {sum_o, carry_o, ovf_o, zero_o};
            pv <= out_valid_o;
            pr <= out_ready_i;
        end
    end

    initial begin
        logic [W-1:0] corner[5];
        logic [W-1:0] ra, rb;
        int t;
        corner[0] = 16'h0000;
        corner[1] = 16'h0001;
        corner[2] = 16'h7FFF;
        corner[3] = 16'h8000;
        corner[4] = 16'hFFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(in_ready_o), 32'd0);
        chk("rst_outputs", 32'({out_valid_o, sum_o, carry_o, ovf_o, zero_o}), 32'd0);
        @(posedge clk);
        #1 rst_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_rst", 32'(in_ready_o), 32'd1);

        rmode = 2;
        send(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        send(16'h7FFF, 16'h0000, 1'b0, 1'b1, 0);
        send(16'h8000, 16'h0001, 1'b1, 1'b1, 0);
        drain();

        // Back-pressure in DONE with a new request held on the input.
        rmode = 1;
        send(16'h00F0, 16'h0F10, 1'b0, 1'b1, 1);
        t = 0;
        while (!out_valid_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("bp_valid_wait", 32'(out_valid_o), 32'd1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_no_accept", 32'(in_ready_o), 32'd0);
            chk("bp_valid", 32'(out_valid_o), 32'd1);
        end
        rmode = 2;
        t = 0;
        while (!(out_valid_o && out_ready_i) && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        @(negedge clk);
        chk("idle_after_hs", 32'({in_ready_o, out_valid_o}), 32'b10);
        @(posedge clk);
        #1;
        exp_q.push_back(model(16'h00F0, 16'h0F10, 1'b0, 1'b1));
        acc_q.push_back(cyc);
        in_valid_i = 1'b0;
        drain();

        // Reset while idx = 2 aborts the transaction.
        rmode = 0;
        send(16'hABCD, 16'h1111, 1'b0, 1'b0, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_i = 1'b1;
        @(posedge clk);
        #1 rst_i = 1'b0;
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        chk("abort_outputs", 32'({out_valid_o, in_ready_o, sum_o, carry_o, ovf_o, zero_o}), 32'd0);
        @(negedge clk);
        chk("abort_ready", 32'(in_ready_o), 32'd1);
        repeat (N + 2) begin
            @(negedge clk);
            chk("abort_no_valid", 32'(out_valid_o), 32'd0);
        end
        send(16'h0001, 16'h0001, 1'b0, 1'b0, 0);
        drain();

        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
            send(ra, rb, 1'($urandom), 1'($urandom), 0);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
